// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter_if : requester / memory handshake bundle for the port arbiter
// Revision 1.0
// ============================================================================
interface mem_port_arbiter_if;
    logic if_req;
    logic ls_req;
    logic ls_write;
    logic MFC;
    logic if_gnt;
    logic ls_gnt;
    logic if_done;
    logic ls_done;
    logic mem_err;
    logic MAR_inEn;
    logic Enable;
    logic RW;
    logic InEnMDR_Out;
    logic OutEnMDR_Out;
    logic busy;

    modport master (
        output if_req, ls_req, ls_write, MFC,
        input  if_gnt, ls_gnt, if_done, ls_done, mem_err,
        input  MAR_inEn, Enable, RW, InEnMDR_Out, OutEnMDR_Out, busy
    );

    modport slave (
        input  if_req, ls_req, ls_write, MFC,
        output if_gnt, ls_gnt, if_done, ls_done, mem_err,
        output MAR_inEn, Enable, RW, InEnMDR_Out, OutEnMDR_Out, busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : round-robin owner of the MAR/MDR memory port with MFC timeout
// Revision 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_ACCESS = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

    localparam logic             c_own_if   = 1'b0;
    localparam logic             c_own_ls   = 1'b1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             write_q, write_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pick;

    logic if_gnt_q, if_gnt_d, ls_gnt_q, ls_gnt_d;
    logic if_done_q, if_done_d, ls_done_q, ls_done_d;
    logic mem_err_q, mem_err_d, mar_q, mar_d;
    logic enable_q, enable_d, rw_q, rw_d;
    logic mdr_in_q, mdr_in_d, mdr_out_q, mdr_out_d, busy_q, busy_d;

    // On a tie the requester that did not own the last access wins.
    assign pick = (bus.if_req && bus.ls_req) ? ~last_q : bus.ls_req;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        write_d = write_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.if_req || bus.ls_req) begin
                    owner_d = pick;
                    write_d = pick & bus.ls_write;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                cnt_d   = '0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (bus.MFC) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == c_cnt_last) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_DONE, S_ERR: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they come straight off flops.
    always_comb begin
        if_gnt_d  = 1'b0;
        ls_gnt_d  = 1'b0;
        if_done_d = 1'b0;
        ls_done_d = 1'b0;
        mem_err_d = 1'b0;
        mar_d     = 1'b0;
        enable_d  = 1'b0;
        rw_d      = 1'b0;
        mdr_in_d  = 1'b0;
        mdr_out_d = 1'b0;
        busy_d    = 1'b0;
        if (state_d != S_IDLE) begin
            if_gnt_d = (owner_d == c_own_if);
            ls_gnt_d = (owner_d == c_own_ls);
            busy_d   = 1'b1;
        end
        case (state_d)
            S_ADDR: mar_d = 1'b1;
            S_ACCESS: begin
                enable_d  = 1'b1;
                rw_d      = ~write_d;
                mdr_in_d  = ~write_d;
                mdr_out_d = write_d;
            end
            S_DONE: begin
                if_done_d = (owner_d == c_own_if);
                ls_done_d = (owner_d == c_own_ls);
            end
            S_ERR:   mem_err_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            owner_q   <= c_own_if;
            write_q   <= 1'b0;
            last_q    <= c_own_ls;
            cnt_q     <= '0;
            if_gnt_q  <= 1'b0;
            ls_gnt_q  <= 1'b0;
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            mem_err_q <= 1'b0;
            mar_q     <= 1'b0;
            enable_q  <= 1'b0;
            rw_q      <= 1'b0;
            mdr_in_q  <= 1'b0;
            mdr_out_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            write_q   <= write_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            if_gnt_q  <= if_gnt_d;
            ls_gnt_q  <= ls_gnt_d;
            if_done_q <= if_done_d;
            ls_done_q <= ls_done_d;
            mem_err_q <= mem_err_d;
            mar_q     <= mar_d;
            enable_q  <= enable_d;
            rw_q      <= rw_d;
            mdr_in_q  <= mdr_in_d;
            mdr_out_q <= mdr_out_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.if_gnt       = if_gnt_q;
    assign bus.ls_gnt       = ls_gnt_q;
    assign bus.if_done      = if_done_q;
    assign bus.ls_done      = ls_done_q;
    assign bus.mem_err      = mem_err_q;
    assign bus.MAR_inEn     = mar_q;
    assign bus.Enable       = enable_q;
    assign bus.RW           = rw_q;
    assign bus.InEnMDR_Out  = mdr_in_q;
    assign bus.OutEnMDR_Out = mdr_out_q;
    assign bus.busy         = busy_q;
endmodule
`default_nettype wire
